// File: rtl/pool2d_stream.sv
// Streaming 2x2/stride-2 average/max pooling with half-row line buffer and valid/ready on both sides.
// Optional fused ReLU on the pooled result when POOL_RELU_EN is defined.
module pool2d_stream #(
   parameter int DATA_W = 32,
   parameter int CH     = 1,
   parameter int FM_W   = 6,
   parameter int FM_H   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DATA_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*DATA_W-1:0] out_data,
   output logic                 frame_done
);

   localparam int HW = FM_W / 2;
   localparam int AW = DATA_W + 2;
   localparam int CW = $clog2(FM_W);
   localparam int RW = $clog2(FM_H);
   localparam int IW = (HW > 1) ? $clog2(HW) : 1;

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic                 mode_q;
   logic                 out_last;
   logic [CH*DATA_W-1:0] pair_q;
   logic [CH*AW-1:0]     lb [HW];
   logic [CH*AW-1:0]     pair_res;
   logic [CH*DATA_W-1:0] blk_res;
   logic [IW-1:0]        col_half;
   logic                 accept;
   logic                 col_last;
   logic                 row_last;
   logic                 fill;
   logic                 emit;

   assign in_ready   = ~out_valid | out_ready;
   assign accept     = in_valid & in_ready;
   assign col_half   = IW'(col >> 1);
   assign col_last   = (col == CW'(FM_W - 1));
   assign row_last   = (row == RW'(FM_H - 1));
   assign fill       = accept & ~row[0] & col[0];
   assign emit       = accept & row[0] & col[0];
   assign frame_done = out_valid & out_ready & out_last;

   // Pair reduction across the current column pair, then block reduction against the buffered upper pair.
   always_comb begin : reduce
      logic signed [DATA_W-1:0] a;
      logic signed [DATA_W-1:0] b;
      logic signed [AW-1:0]     ea;
      logic signed [AW-1:0]     eb;
      logic signed [AW-1:0]     pr;
      logic signed [AW-1:0]     lbv;
      logic signed [AW-1:0]     sum4;
      logic        [DATA_W-1:0] blk;
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      pair_res = '0;
      blk_res  = '0;
      a        = '0;
      b        = '0;
      ea       = '0;
      eb       = '0;
      pr       = '0;
      lbv      = '0;
      sum4     = '0;
      blk      = '0;
      for (int k = 0; k < CH; k++) begin
         a    = pair_q[k*DATA_W +: DATA_W];
         b    = in_data[k*DATA_W +: DATA_W];
         ea   = {{2{a[DATA_W-1]}}, a};
         eb   = {{2{b[DATA_W-1]}}, b};
         pr   = mode_q ? ((ea > eb) ? ea : eb) : (ea + eb);
         lbv  = lb[col_half][k*AW +: AW];
         sum4 = pr + lbv;
         blk  = mode_q ? DATA_W'((pr > lbv) ? pr : lbv) : DATA_W'(sum4 >>> 2);
`ifdef POOL_RELU_EN
         if (blk[DATA_W-1]) blk = '0;
`else
`endif
         pair_res[k*AW +: AW]       = pr;
         blk_res[k*DATA_W +: DATA_W] = blk;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         mode_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            if (row == '0 && col == '0) mode_q <= mode;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= blk_res;
            out_last  <= row_last & col_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // NOTE: pair register and line buffer are not reset; each entry is written earlier in the frame than it is read.
   always_ff @(posedge clk) begin
      if (accept && !col[0]) pair_q <= in_data;
      if (fill) lb[col_half] <= pair_res;
   end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: a 4x4 single-lane instance and a 4x4 two-lane instance share stimulus.
// Expected values are hand-computed; ReLU expectations follow POOL_RELU_EN.
module tb_pool2d_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] din;

   logic        in_ready1, out_valid1, frame_done1;
   logic [31:0] out_data1;
   logic        in_ready2, out_valid2, frame_done2;
   logic [63:0] out_data2;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q1 [$];
   logic [63:0] q2 [$];
   int          fd_idx [$];
   logic [31:0] frm [16];
   logic [31:0] frm_hi [16];

   always #5 clk = ~clk;

   pool2d_stream #(.DATA_W(32), .CH(1), .FM_W(4), .FM_H(4)) u_dut1 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(din[31:0]), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .frame_done(frame_done1)
   );

   pool2d_stream #(.DATA_W(32), .CH(2), .FM_W(4), .FM_H(4)) u_dut2 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(din), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .frame_done(frame_done2)
   );

   // Output handshakes are recorded at the falling edge, half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready) begin
         if (frame_done1) fd_idx.push_back(q1.size());
         q1.push_back(out_data1);
      end
      if (!rst && out_valid2 && out_ready) q2.push_back(out_data2);
   end

   task automatic send_px(input logic [63:0] d);
      bit done = 0;
      int n = 0;
      in_valid = 1'b1;
      din = d;
      while (!done) begin
         @(negedge clk);
         done = (in_ready1 === 1'b1);
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_px timeout: in_ready=%b required 1", in_ready1);
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic m, input bit flip, input bit drain);
      for (int i = 0; i < 16; i++) begin
         mode = (flip && i > 0) ? ~m : m;
         send_px({frm_hi[i], frm[i]});
      end
      if (drain) begin
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic ramp_frame();
      for (int i = 0; i < 16; i++) begin
         frm[i]    = 32'(i);
         frm_hi[i] = 32'd0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready1 !== 1'b1)    begin errors++; $display("FAIL reset in_ready got %b expected 1", in_ready1); end
      checks++; if (out_valid1 !== 1'b0)   begin errors++; $display("FAIL reset out_valid got %b expected 0", out_valid1); end
      checks++; if (out_data1 !== 32'd0)   begin errors++; $display("FAIL reset out_data got %h expected 0", out_data1); end
      checks++; if (frame_done1 !== 1'b0)  begin errors++; $display("FAIL reset frame_done got %b expected 0", frame_done1); end
      checks++; if (out_valid2 !== 1'b0)   begin errors++; $display("FAIL reset out_valid lane2 got %b expected 0", out_valid2); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_avg();
      logic [31:0] exp [4];
      exp = '{32'd2, 32'd4, 32'd10, 32'd12};
      ramp_frame();
      q1.delete(); fd_idx.delete();
      send_frame(1'b0, 1'b0, 1'b1);
      checks++; if (q1.size() !== 4) begin errors++; $display("FAIL avg count got %0d expected 4", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1[i] !== exp[i]) begin errors++; $display("FAIL avg[%0d] got %0d expected %0d", i, q1[i], exp[i]); end
      end
      checks++;
      if (fd_idx.size() != 1 || fd_idx[0] != 3) begin
         errors++; $display("FAIL avg frame_done count %0d expected 1 at output 3", fd_idx.size());
      end
   endtask

   task automatic test_max_mode_latch();
      logic [31:0] exp [4];
      exp = '{32'd5, 32'd7, 32'd13, 32'd15};
      ramp_frame();
      q1.delete(); fd_idx.delete();
      send_frame(1'b1, 1'b1, 1'b1);
      checks++; if (q1.size() !== 4) begin errors++; $display("FAIL max count got %0d expected 4", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1[i] !== exp[i]) begin errors++; $display("FAIL max[%0d] got %0d expected %0d", i, q1[i], exp[i]); end
      end
   endtask

   task automatic test_negative();
      logic [31:0] exp_avg [4];
      logic [31:0] exp_max [4];
`ifdef POOL_RELU_EN
      exp_avg = '{32'd0, 32'h7fffffff, 32'd0, 32'd2};
      exp_max = '{32'd0, 32'h7fffffff, 32'd0, 32'd3};
`else
      exp_avg = '{32'hfffffffd, 32'h7fffffff, 32'h80000000, 32'd2};
      exp_max = '{32'hffffffff, 32'h7fffffff, 32'h80000000, 32'd3};
`endif
      frm = '{32'hffffffff, 32'hfffffffe, 32'h7fffffff, 32'h7fffffff,
              32'hfffffffd, 32'hfffffffc, 32'h7fffffff, 32'h7fffffff,
              32'h80000000, 32'h80000000, 32'd3, 32'd3,
              32'h80000000, 32'h80000000, 32'd3, 32'd2};
      for (int i = 0; i < 16; i++) frm_hi[i] = 32'd0;
      q1.delete();
      send_frame(1'b0, 1'b0, 1'b1);
      send_frame(1'b1, 1'b0, 1'b1);
      checks++; if (q1.size() !== 8) begin errors++; $display("FAIL neg count got %0d expected 8", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1[i] !== exp_avg[i]) begin errors++; $display("FAIL neg_avg[%0d] got %h expected %h", i, q1[i], exp_avg[i]); end
         checks++;
         if (q1[i+4] !== exp_max[i]) begin errors++; $display("FAIL neg_max[%0d] got %h expected %h", i, q1[i+4], exp_max[i]); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp [4];
      exp = '{32'd2, 32'd4, 32'd10, 32'd12};
      ramp_frame();
      q1.delete();
      mode = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_px({frm_hi[i], frm[i]});
      in_valid = 1'b1;
      din = {frm_hi[6], frm[6]};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || out_data1 !== 32'd2) begin
            errors++;
            $display("FAIL stall cycle %0d valid=%b ready=%b data=%0d expected 1 0 2", c, out_valid1, in_ready1, out_data1);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int i = 6; i < 16; i++) send_px({frm_hi[i], frm[i]});
      repeat (3) @(posedge clk);
      #1;
      checks++; if (q1.size() !== 4) begin errors++; $display("FAIL stall count got %0d expected 4", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1[i] !== exp[i]) begin errors++; $display("FAIL stall[%0d] got %0d expected %0d", i, q1[i], exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [8];
      exp = '{32'd2, 32'd4, 32'd10, 32'd12, 32'd5, 32'd7, 32'd13, 32'd15};
      ramp_frame();
      q1.delete(); fd_idx.delete();
      send_frame(1'b0, 1'b0, 1'b0);
      send_frame(1'b1, 1'b0, 1'b1);
      checks++; if (q1.size() !== 8) begin errors++; $display("FAIL b2b count got %0d expected 8", q1.size()); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (q1[i] !== exp[i]) begin errors++; $display("FAIL b2b[%0d] got %0d expected %0d", i, q1[i], exp[i]); end
      end
      checks++;
      if (fd_idx.size() != 2 || fd_idx[0] != 3 || fd_idx[1] != 7) begin
         errors++; $display("FAIL b2b frame_done count %0d expected 2 at outputs 3 and 7", fd_idx.size());
      end
   endtask

   task automatic test_two_lane();
      logic [63:0] exp [4];
      exp = '{{32'd105, 32'd5}, {32'd107, 32'd7}, {32'd113, 32'd13}, {32'd115, 32'd15}};
      for (int i = 0; i < 16; i++) begin
         frm[i]    = 32'(i);
         frm_hi[i] = 32'(100 + i);
      end
      q2.delete();
      send_frame(1'b1, 1'b0, 1'b1);
      checks++; if (q2.size() !== 4) begin errors++; $display("FAIL lanes count got %0d expected 4", q2.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q2[i] !== exp[i]) begin errors++; $display("FAIL lanes[%0d] got %h expected %h", i, q2[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] exp [4];
      exp = '{32'd2, 32'd4, 32'd10, 32'd12};
      ramp_frame();
      mode = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_px({frm_hi[i], frm[i]});
      @(negedge clk);
      checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL midrst pending valid got %b expected 1", out_valid1); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL midrst cleared valid=%b ready=%b expected 0 1", out_valid1, in_ready1);
      end
      @(posedge clk);
      #1;
      q1.delete(); fd_idx.delete();
      out_ready = 1'b1;
      send_frame(1'b0, 1'b0, 1'b1);
      checks++; if (q1.size() !== 4) begin errors++; $display("FAIL midrst count got %0d expected 4", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q1[i] !== exp[i]) begin errors++; $display("FAIL midrst[%0d] got %0d expected %0d", i, q1[i], exp[i]); end
      end
      checks++;
      if (fd_idx.size() != 1 || fd_idx[0] != 3) begin
         errors++; $display("FAIL midrst frame_done count %0d expected 1 at output 3", fd_idx.size());
      end
   endtask

   initial begin
      test_reset();
      test_avg();
      test_max_mode_latch();
      test_negative();
      test_stall();
      test_back_to_back();
      test_two_lane();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
